ws2812_frame_streamer: RTL

//   Downstream consumer of the dual-port frame buffer written by the SPI slave bridge. Reads GRB bytes

---
 rtl/ws2812_frame_streamer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ws2812_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_streamer
// Summary  : Streams GRB bytes from the frame buffer's read port onto a WS2812
//            data line, MSB first, then holds the latch gap and pulses
//            frame_done.
// Revision : 1.0
// ============================================================================
module ws2812_frame_streamer #(
    parameter int NUM_LEDS     = 160,
    parameter int NUM_CHANNELS = 3,
    parameter int ADDR_WIDTH   = 13,
    parameter int BASE_ADDR    = 0,
    parameter int T_TOTAL      = 70,
    parameter int T0H          = 20,
    parameter int T1H          = 50,
    parameter int T_RESET      = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  strip_do,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_TOTAL_BYTES = NUM_LEDS * NUM_CHANNELS;
    localparam int c_PULSE_W     = $clog2(T_TOTAL);
    localparam int c_BYTE_W      = (c_TOTAL_BYTES > 1) ? $clog2(c_TOTAL_BYTES) : 1;
    localparam int c_GAP_W       = (T_RESET > 1) ? $clog2(T_RESET) : 1;

    localparam logic [c_PULSE_W-1:0]  c_PULSE_LAST  = c_PULSE_W'(T_TOTAL - 1);
    localparam logic [c_PULSE_W-1:0]  c_PULSE_FETCH = c_PULSE_W'(2);
    localparam logic [c_PULSE_W-1:0]  c_HIGH_0      = c_PULSE_W'(T0H);
    localparam logic [c_PULSE_W-1:0]  c_HIGH_1      = c_PULSE_W'(T1H);
    localparam logic [c_BYTE_W-1:0]   c_BYTE_LAST   = c_BYTE_W'(c_TOTAL_BYTES - 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_LAST    = c_GAP_W'(T_RESET - 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_PENULT  = c_GAP_W'(T_RESET - 2);
    localparam logic                  c_DONE_ENTRY  = (T_RESET == 1);
    localparam logic [ADDR_WIDTH-1:0] c_BASE        = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_SEND  = 3'd3;
    localparam logic [2:0] c_ST_LATCH = 3'd4;

    logic [2:0]            r_state;
    logic [c_PULSE_W-1:0]  r_pulse_cnt;
    logic [2:0]            r_bit_cnt;
    logic [c_BYTE_W-1:0]   r_byte_cnt;
    logic [c_GAP_W-1:0]    r_gap_cnt;
    logic [7:0]            r_shift;
    logic [7:0]            r_next_byte;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_strip_do;
    logic                  r_busy;
    logic                  r_frame_done;

    logic [c_PULSE_W-1:0]  w_high_len;

    assign w_high_len = r_shift[7] ? c_HIGH_1 : c_HIGH_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_pulse_cnt  <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
            r_next_byte  <= '0;
            r_mem_addr   <= c_BASE;
            r_strip_do   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_strip_do   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        r_mem_addr <= c_BASE;
                        r_state    <= c_ST_FETCH;
                        r_busy     <= 1'b1;
                    end
                end
                c_ST_FETCH: begin
                    r_state <= c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    r_shift     <= mem_rdata;
                    r_mem_addr  <= c_BASE + ADDR_WIDTH'(1);
                    r_bit_cnt   <= '0;
                    r_pulse_cnt <= '0;
                    r_byte_cnt  <= '0;
                    r_state     <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    r_strip_do <= (r_pulse_cnt < w_high_len);
                    // Next byte's address was issued at the previous byte boundary,
                    // so read data is settled by pulse 2 of bit 0.
                    if ((r_pulse_cnt == c_PULSE_FETCH) && (r_bit_cnt == 3'd0)) begin
                        r_next_byte <= mem_rdata;
                    end
                    if (r_pulse_cnt == c_PULSE_LAST) begin
                        r_pulse_cnt <= '0;
                        if (r_bit_cnt != 3'd7) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (r_byte_cnt != c_BYTE_LAST) begin
                            r_shift    <= r_next_byte;
                            r_bit_cnt  <= 3'd0;
                            r_byte_cnt <= r_byte_cnt + c_BYTE_W'(1);
                            r_mem_addr <= c_BASE + ADDR_WIDTH'(r_byte_cnt) + ADDR_WIDTH'(2);
                        end else begin
                            r_state      <= c_ST_LATCH;
                            r_gap_cnt    <= '0;
                            r_frame_done <= c_DONE_ENTRY;
                        end
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + c_PULSE_W'(1);
                    end
                end
                c_ST_LATCH: begin
                    // frame_done is raised one edge early so it lands in the final gap cycle.
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state   <= c_ST_IDLE;
                        r_busy    <= 1'b0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt    <= r_gap_cnt + c_GAP_W'(1);
                        r_frame_done <= (r_gap_cnt == c_GAP_PENULT);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign strip_do   = r_strip_do;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
